// File: rtl/wb_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer_if
//   Bundles the two streaming sides of the writeback trace buffer.
//   The capture side carries one writeback event per cycle from the CPU.
//   The read side is a valid/ready drain of buffered events.
//
//   Capture side (master drives):
//     cap_valid    1   writeback event valid this cycle
//     cap_pc       32  PC of the writeback instruction
//     cap_instr    32  instruction word
//     cap_rwd      5   destination register
//     cap_wb_data  32  writeback data
//
//   Read side:
//     rd_valid     1   buffer non-empty (slave drives)
//     rd_ready     1   consumer accepts head entry (master drives)
//     rd_pc/rd_instr/rd_rwd/rd_wb_data  head entry fields (slave drives)
//
//   Modports:
//     master - the environment: CPU trace source plus drain consumer
//     slave  - the trace buffer itself
// ---------------------------------------------------------------------------
interface wb_trace_buffer_if;
  logic        cap_valid;
  logic [31:0] cap_pc;
  logic [31:0] cap_instr;
  logic [4:0]  cap_rwd;
  logic [31:0] cap_wb_data;

  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [4:0]  rd_rwd;
  logic [31:0] rd_wb_data;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_rwd, cap_wb_data, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_rwd, rd_wb_data
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_rwd, cap_wb_data, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_rwd, rd_wb_data
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer
//   Captures the CPU writeback trace into a first-word-fall-through FIFO
//   under control of an arm/trigger FSM, and drains it over valid/ready.
//   Capture begins with the event whose PC equals trig_pc while ARMED (that
//   event is stored) and continues until stop. Events arriving while the
//   FIFO is full, and not covered by a same-cycle pop, are counted in a
//   saturating drop counter.
//
//   Optional feature macro: TRACE_SKIP_R0_EN
//     defined   - events writing r0 are neither stored nor counted as drops;
//                 an r0 event can still fire the trigger.
//     undefined - every event is eligible.
//
//   Parameters:
//     DEPTH   FIFO entries, power of two, >= 2
//     DROP_W  width of the saturating drop counter
//
//   Ports:
//     clk       in   system clock, rising edge
//     rst_n     in   asynchronous reset, active-low
//     arm       in   pulse, IDLE -> ARMED
//     stop      in   pulse, any state -> IDLE (highest priority)
//     trig_pc   in   PC that starts capture
//     bus       --   capture and drain streams (slave modport)
//     count     out  entries held, 0..DEPTH
//     drop_cnt  out  events lost to a full FIFO, saturating
//     state     out  00 IDLE, 01 ARMED, 10 RUN
// ---------------------------------------------------------------------------
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     stop,
  input  logic [31:0]              trig_pc,
  wb_trace_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rwd;
    logic [31:0] wb_data;
  } entry_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];

  logic   trig_fire;
  logic   rwd_ok;
  logic   eligible;
  logic   full;
  logic   pop;
  logic   push;
  logic   drop;
  entry_t wr_entry;
  entry_t head_entry;

  // Trigger is evaluated on the raw event so an r0 write can still start
  // capture even when r0 events are filtered from storage.
  assign trig_fire = (state_q == ST_ARMED) && bus.cap_valid && (bus.cap_pc == trig_pc);

`ifdef TRACE_SKIP_R0_EN
  assign rwd_ok = |bus.cap_rwd;
`else
  assign rwd_ok = 1'b1;
`endif

  assign eligible = ((state_q == ST_RUN) || trig_fire) && bus.cap_valid && !stop && rwd_ok;
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = bus.rd_valid && bus.rd_ready;
  // When full, a same-cycle pop frees the slot the tail points at, so the
  // push can land there without loss.
  assign push     = eligible && (!full || pop);
  assign drop     = eligible && full && !pop;

  assign wr_entry = '{pc: bus.cap_pc, instr: bus.cap_instr, rwd: bus.cap_rwd,
                      wb_data: bus.cap_wb_data};

  // FSM next state; stop overrides everything including a same-cycle arm.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (arm) state_d = ST_ARMED;
        ST_ARMED: if (trig_fire) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Pointer, occupancy and drop counter next values.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
    if (drop && (drop_cnt_q != {DROP_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (push) mem_d[tail_q] = wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is reset so the FWFT head fields read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // First-word-fall-through: head slot drives the read fields directly.
  assign head_entry     = mem_q[head_q];
  assign bus.rd_valid   = (count_q != '0);
  assign bus.rd_pc      = head_entry.pc;
  assign bus.rd_instr   = head_entry.instr;
  assign bus.rd_rwd     = head_entry.rwd;
  assign bus.rd_wb_data = head_entry.wb_data;

  assign count    = count_q;
  assign drop_cnt = drop_cnt_q;
  assign state    = state_q;

endmodule
